// File: rtl/cv32e40p_voter_scrub2d.sv
// Purpose : TMR majority voter over a replicated 2D register array, with a background
//           scrubber that locates single-replica faults and asks the owner to rewrite them.
// Latency : result_o is combinational; scan findings are visible one cycle after evaluation.
// Backpr. : the scan stalls in REQ until fix_ack_i; multi-replica faults never stall it.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   res1_i/res2_i/res3_i       the three replicas, N_ENTRIES x WIDTH
//   result_o                   bitwise 2-of-3 majority of every entry
//   scrub_en_i                 enables the background scan
//   clear_i                    synchronous clear of err_cnt_o and fatal_o
//   fix_req_o / fix_ack_i      correction request handshake
//   fix_idx_o                  entry to rewrite
//   fix_replica_o              one-hot faulty replica (bit0=res1, bit1=res2, bit2=res3)
//   fix_data_o                 voted value to write back
//   err_cnt_o                  saturating count of mismatching entries seen by the scan
//   fatal_o                    sticky flag for faults not attributable to one replica
//   scan_wrap_o                one-cycle pulse after the last entry has been evaluated
module cv32e40p_voter_scrub2d #(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 8,
  localparam int unsigned IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0]     res1_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0]     res2_i,
  input  logic [N_ENTRIES-1:0][WIDTH-1:0]     res3_i,
  output logic [N_ENTRIES-1:0][WIDTH-1:0]     result_o,
  input  logic                                scrub_en_i,
  input  logic                                clear_i,
  output logic                                fix_req_o,
  input  logic                                fix_ack_i,
  output logic [IDX_W-1:0]                    fix_idx_o,
  output logic [2:0]                          fix_replica_o,
  output logic [WIDTH-1:0]                    fix_data_o,
  output logic [CNT_WIDTH-1:0]                err_cnt_o,
  output logic                                fatal_o,
  output logic                                scan_wrap_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    REQ  = 2'd2
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q;
  logic [IDX_W-1:0]                 idx_next;
  logic                             idx_last;

  logic [N_ENTRIES-1:0][WIDTH-1:0]  maj;
  logic [WIDTH-1:0]                 cur_maj;
  logic [2:0]                       fault;
  logic                             fault_multi;

  logic                             adv;
  logic                             capture;
  logic                             cnt_inc;
  logic                             fatal_set;

  logic [IDX_W-1:0]                 fix_idx_q;
  logic [2:0]                       fix_replica_q;
  logic [WIDTH-1:0]                 fix_data_q;
  logic [CNT_WIDTH-1:0]             err_cnt_q;
  logic                             fatal_q;
  logic                             wrap_q;

  // Bitwise majority over every bit of every entry.
  always_comb begin
    maj = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      maj[i] = (res1_i[i] & res2_i[i]) | (res1_i[i] & res3_i[i]) | (res2_i[i] & res3_i[i]);
    end
  end

  assign result_o = maj;

  // Per-replica disagreement for the entry under the scan pointer.
  assign cur_maj  = maj[idx_q];
  assign fault[0] = (res1_i[idx_q] != cur_maj);
  assign fault[1] = (res2_i[idx_q] != cur_maj);
  assign fault[2] = (res3_i[idx_q] != cur_maj);

  // Two or more replicas disagreeing cannot be repaired from a single rewrite.
  assign fault_multi = (fault[0] & fault[1]) | (fault[0] & fault[2]) | (fault[1] & fault[2]);

  // The index only ever takes values 0..N_ENTRIES-1, so the wrap is explicit
  // rather than relying on a power-of-two rollover.
  assign idx_last = (idx_q == IDX_W'(N_ENTRIES - 1));
  assign idx_next = idx_last ? '0 : idx_q + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    adv       = 1'b0;
    capture   = 1'b0;
    cnt_inc   = 1'b0;
    fatal_set = 1'b0;

    case (state_q)
      IDLE: begin
        // The held index is resumed, not restarted.
        if (scrub_en_i) begin
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (!scrub_en_i) begin
          // Leave without evaluating so the current entry is checked on resume.
          state_d = IDLE;
        end else begin
          adv = 1'b1;
          if (fault_multi) begin
            fatal_set = 1'b1;
            cnt_inc   = 1'b1;
          end else if (|fault) begin
            capture = 1'b1;
            cnt_inc = 1'b1;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        // Losing scrub_en_i here does not abort; the handshake always completes.
        if (fix_ack_i) begin
          state_d = scrub_en_i ? SCAN : IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      fix_idx_q     <= '0;
      fix_replica_q <= '0;
      fix_data_q    <= '0;
      err_cnt_q     <= '0;
      fatal_q       <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      state_q <= state_d;

      if (adv) begin
        idx_q <= idx_next;
      end

      // Pulses after the last entry is evaluated, whether or not it raised a request.
      wrap_q <= adv & idx_last;

      // Snapshot so the request payload stays stable while the replicas move.
      if (capture) begin
        fix_idx_q     <= idx_q;
        fix_replica_q <= fault;
        fix_data_q    <= cur_maj;
      end

      // Clear has priority over a same-cycle detection.
      if (clear_i) begin
        err_cnt_q <= '0;
      end else if (cnt_inc && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
      end

      if (clear_i) begin
        fatal_q <= 1'b0;
      end else if (fatal_set) begin
        fatal_q <= 1'b1;
      end
    end
  end

  // Decoded straight from the state register so an asynchronous reset drops it at once.
  assign fix_req_o     = (state_q == REQ);
  assign fix_idx_o     = fix_idx_q;
  assign fix_replica_o = fix_replica_q;
  assign fix_data_o    = fix_data_q;
  assign err_cnt_o     = err_cnt_q;
  assign fatal_o       = fatal_q;
  assign scan_wrap_o   = wrap_q;

endmodule

// File: tb/tb_cv32e40p_voter_scrub2d.sv
// Purpose : directed checks of the TMR voter/scrubber, a 16-entry and a 5-entry instance.
// Latency : outputs are sampled 1 time unit after each rising clock edge.
// Backpr. : fix_ack_i is driven directly to exercise held and immediate acknowledgements.
module tb_cv32e40p_voter_scrub2d;

  logic clk;
  int   n_chk;
  int   n_pass;
  int   cyc;

  // 16-entry instance, 8-bit counter
  logic                 rst_n;
  logic [15:0][31:0]    res1, res2, res3, result;
  logic                 scrub_en, clear, fix_req, fix_ack, fatal, wrap;
  logic [3:0]           fix_idx;
  logic [2:0]           fix_replica;
  logic [31:0]          fix_data;
  logic [7:0]           err_cnt;

  // 5-entry instance, 2-bit counter
  logic                 a_rst_n;
  logic [4:0][31:0]     a_res1, a_res2, a_res3, a_result;
  logic                 a_scrub_en, a_clear, a_fix_req, a_fix_ack, a_fatal, a_wrap;
  logic [2:0]           a_fix_idx;
  logic [2:0]           a_fix_replica;
  logic [31:0]          a_fix_data;
  logic [1:0]           a_err_cnt;

  cv32e40p_voter_scrub2d #(.N_ENTRIES(16), .WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .res1_i(res1), .res2_i(res2), .res3_i(res3), .result_o(result),
    .scrub_en_i(scrub_en), .clear_i(clear),
    .fix_req_o(fix_req), .fix_ack_i(fix_ack), .fix_idx_o(fix_idx),
    .fix_replica_o(fix_replica), .fix_data_o(fix_data),
    .err_cnt_o(err_cnt), .fatal_o(fatal), .scan_wrap_o(wrap)
  );

  cv32e40p_voter_scrub2d #(.N_ENTRIES(5), .WIDTH(32), .CNT_WIDTH(2)) dut5 (
    .clk(clk), .rst_n(a_rst_n),
    .res1_i(a_res1), .res2_i(a_res2), .res3_i(a_res3), .result_o(a_result),
    .scrub_en_i(a_scrub_en), .clear_i(a_clear),
    .fix_req_o(a_fix_req), .fix_ack_i(a_fix_ack), .fix_idx_o(a_fix_idx),
    .fix_replica_o(a_fix_replica), .fix_data_o(a_fix_data),
    .err_cnt_o(a_err_cnt), .fatal_o(a_fatal), .scan_wrap_o(a_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int first;
    int second;
    int nreq;
    int bad;

    clk = 1'b0; n_chk = 0; n_pass = 0; cyc = 0;
    rst_n = 1'b0; scrub_en = 1'b0; clear = 1'b0; fix_ack = 1'b0;
    a_rst_n = 1'b0; a_scrub_en = 1'b0; a_clear = 1'b0; a_fix_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      res1[i] = 32'h1000_0000 + 32'(i);
      res2[i] = 32'h1000_0000 + 32'(i);
      res3[i] = 32'h1000_0000 + 32'(i);
    end
    for (int i = 0; i < 5; i++) begin
      a_res1[i] = 32'h2000_0000 + 32'(i);
      a_res2[i] = 32'h2000_0000 + 32'(i);
      a_res3[i] = 32'h2000_0000 + 32'(i);
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_req",     64'(fix_req),     64'd0);
    check("rst_idx",     64'(fix_idx),     64'd0);
    check("rst_replica", 64'(fix_replica), 64'd0);
    check("rst_data",    64'(fix_data),    64'd0);
    check("rst_err",     64'(err_cnt),     64'd0);
    check("rst_fatal",   64'(fatal),       64'd0);
    check("rst_wrap",    64'(wrap),        64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Clean array: no requests, wrap every 16 cycles.
    scrub_en = 1'b1;
    c0 = cyc; first = -1; second = -1; nreq = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (wrap) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (fix_req) nreq++;
    end
    check("clean_wrap_first",  64'(first),          64'(c0 + 17));
    check("clean_wrap_period", 64'(second - first), 64'd16);
    check("clean_no_req",      64'(nreq),           64'd0);
    check("clean_err",         64'(err_cnt),        64'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("vote_clean[%0d]", i), 64'(result[i]), 64'(32'h1000_0000 + 32'(i)));
    end

    // Single fault in replica 2, entry 5, MSB.
    scrub_en = 1'b0;
    tick();
    res2[5][31] = ~res2[5][31];
    check("vote_single_5", 64'(result[5]), 64'h1000_0005);
    scrub_en = 1'b1;
    for (int k = 0; k < 20 && !fix_req; k++) tick();
    check("single_req",     64'(fix_req),     64'd1);
    check("single_idx",     64'(fix_idx),     64'd5);
    check("single_replica", 64'(fix_replica), 64'b010);
    check("single_data",    64'(fix_data),    64'h1000_0005);
    check("single_err",     64'(err_cnt),     64'd1);
    // Replicas move while the request is pending; payload must not.
    res2[5] = 32'h1000_0005;
    res3[6][7] = ~res3[6][7];
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (fix_req !== 1'b1 || fix_idx !== 4'd5 || fix_replica !== 3'b010 ||
          fix_data !== 32'h1000_0005) bad++;
    end
    check("hold_stable", 64'(bad), 64'd0);
    fix_ack = 1'b1;
    tick();
    fix_ack = 1'b0;
    check("ack_req_drop", 64'(fix_req), 64'd0);
    // Scan resumes at entry 6, which now has a replica-3 fault.
    tick();
    check("resume_req",     64'(fix_req),     64'd1);
    check("resume_idx",     64'(fix_idx),     64'd6);
    check("resume_replica", 64'(fix_replica), 64'b100);
    check("resume_data",    64'(fix_data),    64'h1000_0006);
    check("resume_err",     64'(err_cnt),     64'd2);
    fix_ack = 1'b1;
    tick();
    fix_ack = 1'b0;
    res3[6] = 32'h1000_0006;

    // Multi-replica fault in entry 15.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_err",   64'(err_cnt), 64'd0);
    check("clear_fatal", 64'(fatal),   64'd0);
    res1[15][0] = ~res1[15][0];
    res3[15][1] = ~res3[15][1];
    check("vote_multi_15", 64'(result[15]), 64'h1000_000F);
    nreq = 0;
    for (int k = 0; k < 20 && !fatal; k++) begin
      tick();
      if (fix_req) nreq++;
    end
    check("multi_fatal",  64'(fatal),   64'd1);
    check("multi_wrap",   64'(wrap),    64'd1);
    check("multi_err",    64'(err_cnt), 64'd1);
    check("multi_no_req", 64'(nreq),    64'd0);
    res1[15] = 32'h1000_000F;
    res3[15] = 32'h1000_000F;
    scrub_en = 1'b0;
    tick();
    tick();
    check("fatal_sticky", 64'(fatal), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear2_err",   64'(err_cnt), 64'd0);
    check("clear2_fatal", 64'(fatal),   64'd0);

    // 5-entry instance: saturation with immediate acks and wrap from 4 to 0.
    check("a_rst_req", 64'(a_fix_req), 64'd0);
    check("a_rst_err", 64'(a_err_cnt), 64'd0);
    a_rst_n = 1'b1;
    tick();
    a_res1[2][4] = ~a_res1[2][4];
    a_fix_ack = 1'b1;
    a_scrub_en = 1'b1;
    c0 = cyc; first = -1; second = -1; bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (a_wrap) begin
        if (first < 0) first = cyc;
        else if (second < 0) second = cyc;
      end
      if (a_fix_req && (a_fix_idx !== 3'd2 || a_fix_replica !== 3'b001 ||
                        a_fix_data !== 32'h2000_0002)) bad++;
    end
    check("a_wrap_first",  64'(first),          64'(c0 + 7));
    check("a_wrap_period", 64'(second - first), 64'd6);
    check("a_payload",     64'(bad),            64'd0);
    check("a_saturate",    64'(a_err_cnt),      64'd3);
    check("a_no_fatal",    64'(a_fatal),        64'd0);

    // Clear lands in the same cycle as a detection of entry 2.
    for (int k = 0; k < 10 && !a_fix_req; k++) tick();
    check("a_req_seen", 64'(a_fix_req), 64'd1);
    repeat (5) tick();
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("a_clear_vs_inc_req", 64'(a_fix_req), 64'd1);
    check("a_clear_vs_inc_err", 64'(a_err_cnt), 64'd0);

    // Enable drops mid-request: handshake completes, then idle.
    a_fix_ack = 1'b0;
    a_scrub_en = 1'b0;
    repeat (3) tick();
    check("a_req_no_abort", 64'(a_fix_req), 64'd1);
    a_fix_ack = 1'b1;
    tick();
    a_fix_ack = 1'b0;
    check("a_req_done", 64'(a_fix_req), 64'd0);
    // Move the fault to entry 3, where the held index points.
    a_res1[2] = 32'h2000_0002;
    a_res2[3][9] = ~a_res2[3][9];
    tick();
    check("a_idle_no_req", 64'(a_fix_req), 64'd0);
    a_scrub_en = 1'b1;
    tick();
    check("a_enter_scan", 64'(a_fix_req), 64'd0);
    tick();
    check("a_held_req",     64'(a_fix_req),     64'd1);
    check("a_held_idx",     64'(a_fix_idx),     64'd3);
    check("a_held_replica", 64'(a_fix_replica), 64'b010);
    check("a_held_data",    64'(a_fix_data),    64'h2000_0003);

    // Asynchronous reset in the middle of a request.
    a_rst_n = 1'b0;
    #1;
    check("a_async_rst_req", 64'(a_fix_req), 64'd0);
    check("a_async_rst_idx", 64'(a_fix_idx), 64'd0);
    check("a_async_rst_err", 64'(a_err_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
